sap1_ctrl_seq: RTL

// SAP-1 controller-sequencer: 6-state ring counter (T1..T6) plus opcode decode producing the 12-bit control word.

---
 rtl/sap1_pkg.sv | 59 +++++
 rtl/sap1_edge_det.sv | 21 ++
 rtl/sap1_ctrl_seq.sv | 97 +++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 controller-sequencer shared definitions: opcodes, control-bit positions, control words.
package sap1_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned CW_W = 12;
  localparam int unsigned T_W  = 6;

  localparam logic [OPW-1:0] OP_LDA = 4'h0;
  localparam logic [OPW-1:0] OP_ADD = 4'h1;
  localparam logic [OPW-1:0] OP_SUB = 4'h2;
  localparam logic [OPW-1:0] OP_OUT = 4'hE;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  // Control word bit positions, MSB first: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
  localparam int unsigned B_CP  = 11;
  localparam int unsigned B_EP  = 10;
  localparam int unsigned B_NLM = 9;
  localparam int unsigned B_NCE = 8;
  localparam int unsigned B_NLI = 7;
  localparam int unsigned B_NEI = 6;
  localparam int unsigned B_NLA = 5;
  localparam int unsigned B_EA  = 4;
  localparam int unsigned B_SU  = 3;
  localparam int unsigned B_EU  = 2;
  localparam int unsigned B_NLB = 1;
  localparam int unsigned B_NLO = 0;

  // Single-bit mask; XOR against the idle word asserts a control regardless of polarity
  function automatic logic [CW_W-1:0] cw_bit(input int unsigned idx);
    return CW_W'(1) << idx;
  endfunction

  localparam logic [CW_W-1:0] CW_IDLE = cw_bit(B_NLM) | cw_bit(B_NCE) | cw_bit(B_NLI) |
                                        cw_bit(B_NEI) | cw_bit(B_NLA) | cw_bit(B_NLB) |
                                        cw_bit(B_NLO);

  // Fetch words; the T1 word on this board also drives nCE alongside Ep/nLm
  localparam logic [CW_W-1:0] CW_T1 = CW_IDLE ^ cw_bit(B_EP) ^ cw_bit(B_NLM) ^ cw_bit(B_NCE);
  localparam logic [CW_W-1:0] CW_T2 = CW_IDLE ^ cw_bit(B_CP);
  localparam logic [CW_W-1:0] CW_T3 = CW_IDLE ^ cw_bit(B_NCE) ^ cw_bit(B_NLI);

  // Execute words
  localparam logic [CW_W-1:0] CW_MAR_IR = CW_IDLE ^ cw_bit(B_NLM) ^ cw_bit(B_NEI);
  localparam logic [CW_W-1:0] CW_MEM_A  = CW_IDLE ^ cw_bit(B_NCE) ^ cw_bit(B_NLA);
  localparam logic [CW_W-1:0] CW_MEM_B  = CW_IDLE ^ cw_bit(B_NCE) ^ cw_bit(B_NLB);
  localparam logic [CW_W-1:0] CW_ADD_T6 = CW_IDLE ^ cw_bit(B_NLA) ^ cw_bit(B_EU);
  localparam logic [CW_W-1:0] CW_SUB_T6 = CW_ADD_T6 ^ cw_bit(B_SU);
  localparam logic [CW_W-1:0] CW_OUT_T4 = CW_IDLE ^ cw_bit(B_EA) ^ cw_bit(B_NLO);

  typedef enum logic [T_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

endpackage

// File: rtl/sap1_edge_det.sv
// Single history flop edge detector for front-panel level signals sampled on the board clock.
module sap1_edge_det (
  input  logic clk,
  input  logic nCLR,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic in_q;

  // History flop, cleared on reset
  always_ff @(posedge clk) begin
    if (!nCLR) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign rise = in & ~in_q;
  assign fall = in_q & ~in;

endmodule

// File: rtl/sap1_ctrl_seq.sv
// SAP-1 controller-sequencer: T1..T6 ring advanced on CLK falls, registered opcode decode, sticky halt.
module sap1_ctrl_seq
  import sap1_pkg::*;
(
  input  logic            clk,
  input  logic            nCLR,
  input  logic            CLK,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  output logic [CW_W-1:0] cw,
  output logic [T_W-1:0]  tstate,
  output logic            nHLT
);

  tstate_e         state_q, state_d;
  logic [CW_W-1:0] cw_d;
  logic            nhlt_d;
  logic            clk_fall;
  logic            clk_rise_unused;

  sap1_edge_det u_clk_edge (
    .clk  (clk),
    .nCLR (nCLR),
    .in   (CLK),
    .rise (clk_rise_unused),
    .fall (clk_fall)
  );

  function automatic tstate_e next_t(input tstate_e t);
    case (t)
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      default: return T1;
    endcase
  endfunction

  function automatic logic [CW_W-1:0] decode(input tstate_e t, input logic [OPW-1:0] op);
    logic [CW_W-1:0] w;
    w = CW_IDLE;
    case (t)
      T1: w = CW_T1;
      T2: w = CW_T2;
      T3: w = CW_T3;
      T4: begin
        if (op == OP_LDA || op == OP_ADD || op == OP_SUB) w = CW_MAR_IR;
        else if (op == OP_OUT)                            w = CW_OUT_T4;
      end
      T5: begin
        if (op == OP_LDA)                      w = CW_MEM_A;
        else if (op == OP_ADD || op == OP_SUB) w = CW_MEM_B;
      end
      T6: begin
        if (op == OP_ADD)      w = CW_ADD_T6;
        else if (op == OP_SUB) w = CW_SUB_T6;
      end
      default: w = CW_IDLE;
    endcase
    return w;
  endfunction

  // Next ring state, halt and control word; halt beats run, run=0 beats a fall
  always_comb begin
    state_d = state_q;
    cw_d    = CW_IDLE;
    nhlt_d  = nHLT;
    if (!nHLT) begin
      state_d = state_q;
      cw_d    = CW_IDLE;
    end else if (!run) begin
      state_d = T1;
      cw_d    = CW_IDLE;
    end else begin
      if (clk_fall) state_d = next_t(state_q);
      if (clk_fall && state_q == T3 && opcode == OP_HLT) nhlt_d = 1'b0;
      cw_d = decode(state_d, opcode);
    end
  end

  // State, control word and halt registers
  always_ff @(posedge clk) begin
    if (!nCLR) begin
      state_q <= T1;
      cw      <= CW_T1;
      nHLT    <= 1'b1;
    end else begin
      state_q <= state_d;
      cw      <= cw_d;
      nHLT    <= nhlt_d;
    end
  end

  assign tstate = state_q;

endmodule
